// File: rtl/icache_refill.sv
// Instruction-cache miss handler: detects fetch misses, refills the line over an
// AXI4 INCR read burst, owns the per-set LRU bits and serves uncached fetches.
module icache_refill #(
    parameter int         AXI_DW = 32,
    parameter int         LINE_W = 64,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [63:0]       req_addr,
    input  logic              req_cache,
    input  logic [1:0]        hit,
    input  logic              flush,
    output logic              stall_req,
    output logic              refresh,
    output logic [LINE_W-1:0] cacheline_new,
    output logic              lru,
    output logic              uc_valid,
    output logic [LINE_W-1:0] uc_rdata,
    output logic              bus_err,
    output logic              arvalid,
    input  logic              arready,
    output logic [63:0]       araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [3:0]        arid,
    input  logic              rvalid,
    output logic              rready,
    input  logic [AXI_DW-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast
);

    localparam int BEATS = LINE_W / AXI_DW;
    localparam int BCW   = $clog2(BEATS + 1);
    localparam logic [BCW-1:0] BEATS_C = BCW'(BEATS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_FILL = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       addr_q, addr_d;
    logic              cached_q, cached_d;
    logic              victim_q, victim_d;
    logic              flushed_q, flushed_d;
    logic              err_q, err_d;
    logic [BCW-1:0]    beat_q, beat_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [63:0]       lru_q, lru_d;

    logic [5:0] req_idx;
    logic [5:0] fill_idx;
    logic       miss;
    logic       unused_addr_bits;

    assign req_idx          = req_addr[8:3];
    assign fill_idx         = addr_q[8:3];
    assign miss             = req_valid & (~req_cache | (hit == 2'b00));
    assign unused_addr_bits = ^req_addr[2:0];

    assign araddr        = addr_q;
    assign cacheline_new = line_q;
    assign uc_rdata      = line_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cached_d  = cached_q;
        victim_d  = victim_q;
        flushed_d = flushed_q;
        err_d     = err_q;
        beat_d    = beat_q;
        line_d    = line_q;
        lru_d     = lru_q;

        stall_req = 1'b0;
        refresh   = 1'b0;
        uc_valid  = 1'b0;
        bus_err   = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        lru       = victim_q;
        arlen     = 8'd0;
        arsize    = 3'd0;
        arburst   = 2'd0;
        arid      = 4'd0;

        case (state_q)
            S_IDLE: begin
                stall_req = miss;
                lru       = lru_q[req_idx];
                // Only a genuine cached hit touches LRU; the victim is the other way.
                if (req_valid && req_cache && hit == 2'b01) begin
                    lru_d[req_idx] = 1'b1;
                end else if (req_valid && req_cache && hit == 2'b10) begin
                    lru_d[req_idx] = 1'b0;
                end
                if (miss) begin
                    state_d   = S_AR;
                    addr_d    = {req_addr[63:3], 3'b000};
                    cached_d  = req_cache;
                    victim_d  = lru_q[req_idx];
                    flushed_d = 1'b0;
                    err_d     = 1'b0;
                    beat_d    = '0;
                    line_d    = '0;
                end
            end
            S_AR: begin
                stall_req = 1'b1;
                arvalid   = 1'b1;
                arlen     = 8'(BEATS - 1);
                arsize    = 3'($clog2(AXI_DW / 8));
                arburst   = 2'b01;
                arid      = AXI_ID;
                if (flush) flushed_d = 1'b1;
                if (arready) state_d = S_R;
            end
            S_R: begin
                stall_req = 1'b1;
                rready    = 1'b1;
                if (flush) flushed_d = 1'b1;
                if (rvalid) begin
                    if (rresp != 2'b00) err_d = 1'b1;
                    // Beats beyond the line size are accepted but dropped.
                    if (beat_q < BEATS_C) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (beat_q == BCW'(k)) line_d[k*AXI_DW +: AXI_DW] = rdata;
                        end
                        beat_d = beat_q + BCW'(1);
                    end
                    if (rlast) state_d = S_FILL;
                end
            end
            S_FILL: begin
                stall_req = 1'b1;
                state_d   = S_IDLE;
                if (flush) flushed_d = 1'b1;
                if (err_q) begin
                    bus_err = 1'b1;
                end else if (!flushed_q && cached_q) begin
                    refresh          = 1'b1;
                    lru_d[fill_idx]  = ~victim_q;
                end else if (!flushed_q) begin
                    uc_valid = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cached_q  <= 1'b0;
            victim_q  <= 1'b0;
            flushed_q <= 1'b0;
            err_q     <= 1'b0;
            beat_q    <= '0;
            line_q    <= '0;
            lru_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cached_q  <= cached_d;
            victim_q  <= victim_d;
            flushed_q <= flushed_d;
            err_q     <= err_d;
            beat_q    <= beat_d;
            line_q    <= line_d;
            lru_q     <= lru_d;
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Randomized bench for icache_refill: driver plays fetch + AXI slave, a monitor
// matches every line/uncached/error strobe against a queue of expected results.
module tb_icache_refill;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_cache;
    logic [1:0]  hit;
    logic        flush;
    logic        stall_req;
    logic        refresh;
    logic [63:0] cacheline_new;
    logic        lru;
    logic        uc_valid;
    logic [63:0] uc_rdata;
    logic        bus_err;
    logic        arvalid;
    logic        arready;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    icache_refill dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_cache(req_cache),
        .hit(hit), .flush(flush),
        .stall_req(stall_req), .refresh(refresh), .cacheline_new(cacheline_new),
        .lru(lru), .uc_valid(uc_valid), .uc_rdata(uc_rdata), .bus_err(bus_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind bits: {bus_err, uc_valid, refresh}
    typedef struct {
        logic [2:0]  kind;
        logic [63:0] data;
        logic        lru;
    } exp_t;

    exp_t exp_q[$];
    logic lru_model [64];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t m;
        if (refresh || uc_valid || bus_err) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_strobe: got refresh=%b uc_valid=%b bus_err=%b expected none at %0t",
                         refresh, uc_valid, bus_err, $time);
            end else begin
                m = exp_q.pop_front();
                chk("strobe_kind", 64'({bus_err, uc_valid, refresh}), 64'(m.kind));
                if (m.kind == 3'b001) begin
                    chk("refill_line", cacheline_new, m.data);
                    chk("refill_lru", 64'(lru), 64'(m.lru));
                end
                if (m.kind == 3'b010) chk("uc_data", uc_rdata, m.data);
                $display("[TB] strobe kind=%b line=%h lru=%b", m.kind, cacheline_new, lru);
            end
        end
    end

    task automatic do_miss(input logic [63:0] a, input logic c, input logic [31:0] b0,
                           input logic [31:0] b1, input logic [1:0] r0, input logic [1:0] r1,
                           input int ar_dly, input int gap, input logic fl);
        logic [5:0]  idx;
        logic        victim;
        logic        err;
        logic [63:0] ar_exp;
        exp_t        e;
        idx    = a[8:3];
        victim = lru_model[idx];
        err    = (r0 != 2'b00) || (r1 != 2'b00);
        ar_exp = {a[63:3], 3'b000};
        req_valid = 1'b1; req_addr = a; req_cache = c; hit = 2'b00;
        @(negedge clk);
        chk("miss_stall", 64'(stall_req), 64'd1);
        chk("miss_lru", 64'(lru), 64'(victim));
        chk("miss_no_ar", 64'(arvalid), 64'd0);
        if (err) begin
            e.kind = 3'b100; e.data = '0; e.lru = 1'b0; exp_q.push_back(e);
        end else if (!fl) begin
            e.kind = c ? 3'b001 : 3'b010; e.data = {b1, b0}; e.lru = victim; exp_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = {$urandom(), $urandom()};
        for (int d = 0; d <= ar_dly; d++) begin
            arready = (d == ar_dly);
            @(negedge clk);
            chk("ar_valid", 64'(arvalid), 64'd1);
            chk("ar_addr", araddr, ar_exp);
            chk("ar_attr", 64'({arlen, arsize, arburst, arid}), 64'({8'd1, 3'b010, 2'b01, 4'd0}));
            chk("ar_lru", 64'(lru), 64'(victim));
            chk("ar_no_rready", 64'(rready), 64'd0);
            @(posedge clk); #1;
        end
        arready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int g = 0; g < gap; g++) begin
                rvalid = 1'b0; rdata = $urandom(); rresp = 2'($urandom()); rlast = 1'b0;
                @(negedge clk);
                chk("r_gap_rready", 64'(rready), 64'd1);
                @(posedge clk); #1;
            end
            rvalid = 1'b1; rdata = (k == 1) ? b1 : b0; rresp = (k == 1) ? r1 : r0;
            rlast = (k == 1); flush = fl && (k == 0);
            @(negedge clk);
            chk("r_rready", 64'(rready), 64'd1);
            chk("r_stall", 64'(stall_req), 64'd1);
            @(posedge clk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0; flush = 1'b0; rresp = 2'b00;
        @(negedge clk);
        chk("fill_stall", 64'(stall_req), 64'd1);
        chk("fill_lru", 64'(lru), 64'(victim));
        chk("fill_no_rready", 64'(rready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_fill_stall", 64'(stall_req), 64'd0);
        chk("post_fill_no_ar", 64'(arvalid), 64'd0);
        @(posedge clk); #1;
        if (!err && !fl && c) lru_model[idx] = ~victim;
        $display("[TB] miss addr=%h cache=%b err=%b flush=%b victim=%b", a, c, err, fl, victim);
    endtask

    task automatic do_hit(input logic [63:0] a, input logic [1:0] h, input logic fl);
        logic [5:0] idx;
        idx = a[8:3];
        req_valid = 1'b1; req_addr = a; req_cache = 1'b1; hit = h; flush = fl;
        @(negedge clk);
        chk("hit_stall", 64'(stall_req), 64'd0);
        chk("hit_lru", 64'(lru), 64'(lru_model[idx]));
        chk("hit_no_ar", 64'(arvalid), 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; hit = 2'b00; flush = 1'b0;
        lru_model[idx] = (h == 2'b01);
        $display("[TB] hit addr=%h way=%b", a, h);
    endtask

    task automatic do_probe(input logic [63:0] a, input logic fl);
        req_valid = 1'b0; req_addr = a; flush = fl;
        @(negedge clk);
        chk("probe_lru", 64'(lru), 64'(lru_model[a[8:3]]));
        chk("probe_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        $display("[TB] probe set=%0d lru=%b", a[8:3], lru);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, 64'({stall_req, refresh, lru, uc_valid, bus_err, arvalid, rready,
                               arlen, arsize, arburst, arid}), 64'd0);
        chk({nm, "_line"}, cacheline_new, 64'd0);
        chk({nm, "_uc"}, uc_rdata, 64'd0);
        chk({nm, "_araddr"}, araddr, 64'd0);
    endtask

    initial begin
        logic [63:0] a;
        int          op;
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_cache = 1'b0; hit = 2'b00;
        flush = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        for (int i = 0; i < 64; i++) lru_model[i] = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Cold cached miss, then the set's LRU points at the other way.
        do_miss(64'h8000_0010, 1'b1, 32'h1111_1111, 32'h2222_2222, 2'b00, 2'b00, 0, 0, 1'b0);
        do_probe(64'h8000_0010, 1'b0);
        // Hits on set 5.
        do_hit(64'h0000_0028, 2'b10, 1'b0);
        do_probe(64'h0000_0028, 1'b0);
        do_hit(64'h0000_0028, 2'b01, 1'b0);
        do_probe(64'h0000_0028, 1'b1);
        // Uncached, flushed, and error fills.
        do_miss(64'h1000_0008, 1'b0, 32'hAAAA_5555, 32'h0F0F_1234, 2'b00, 2'b00, 0, 0, 1'b0);
        do_probe(64'h1000_0008, 1'b0);
        do_miss(64'h2000_0040, 1'b1, 32'h3333_3333, 32'h4444_4444, 2'b00, 2'b00, 1, 1, 1'b1);
        do_probe(64'h2000_0040, 1'b0);
        do_miss(64'h3000_0018, 1'b1, 32'h5555_5555, 32'h6666_6666, 2'b10, 2'b00, 0, 0, 1'b0);
        do_probe(64'h3000_0018, 1'b0);
        // Slow AR acceptance.
        do_miss(64'h5000_0035, 1'b1, 32'h7777_7777, 32'h8888_8888, 2'b00, 2'b00, 5, 0, 1'b0);

        // Asynchronous reset in the middle of a burst.
        req_valid = 1'b1; req_addr = 64'h4000_0128; req_cache = 1'b1; hit = 2'b00;
        @(posedge clk); #1;
        req_valid = 1'b0; arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00; rlast = 1'b0;
        @(posedge clk); #1;
        rvalid = 1'b0;
        #2 rst = 1'b0;
        #1 chk_all_zero("mid_burst_reset");
        $display("[TB] reset during burst");
        for (int i = 0; i < 64; i++) lru_model[i] = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        do_probe(64'h8000_0010, 1'b0);
        do_probe(64'h0000_0028, 1'b0);

        for (int n = 0; n < 300; n++) begin
            a = {$urandom(), $urandom()};
            a[8:3] = 6'($urandom_range(0, 7));
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                do_miss(a, (op != 4), $urandom(), $urandom(),
                        ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                        ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                        $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 4) == 0));
            end else if (op <= 7) begin
                do_hit(a, ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10, ($urandom_range(0, 3) == 0));
            end else begin
                do_probe(a, ($urandom_range(0, 1) == 1));
            end
        end

        repeat (2) @(posedge clk);
        chk("expected_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
